// File: rtl/sub4_serial.sv
// Bit-serial 4-bit subtractor D = A - B, LSB first, one bit per clock with a registered borrow chain.
// Start accepted in IDLE/DONE; result and done appear 4 cycles later; start is ignored while busy.
module sub4_serial #(
   parameter bit DONE_PULSE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic a3,
   input  logic a2,
   input  logic a1,
   input  logic a0,
   input  logic b3,
   input  logic b2,
   input  logic b1,
   input  logic b0,
   output logic busy,
   output logic done,
   output logic d3,
   output logic d2,
   output logic d1,
   output logic d0,
   output logic bo4,
   output logic bo3,
   output logic bo2,
   output logic bo1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] d_q, d_d;
   logic [3:0] bo_q, bo_d;
   logic       br_q, br_d;
   logic [1:0] idx_q, idx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic       a_bit, b_bit, br_new;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      bo_d    = bo_q;
      br_d    = br_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = done_q;

      a_bit   = a_q[idx_q];
      b_bit   = b_q[idx_q];
      br_new  = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = {a3, a2, a1, a0};
               b_d     = {b3, b2, b1, b0};
               d_d     = 4'd0;
               bo_d    = 4'd0;
               br_d    = 1'b0;
               idx_d   = 2'd0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               state_d = RUN;
            end else if (state_q == DONE && DONE_PULSE) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         RUN: begin
            // Each bit stage stores its own borrow-out so the full ripple chain is visible.
            d_d[idx_q]  = a_bit ^ b_bit ^ br_q;
            bo_d[idx_q] = br_new;
            br_d        = br_new;
            idx_d       = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         d_q     <= 4'd0;
         bo_q    <= 4'd0;
         br_q    <= 1'b0;
         idx_q   <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         bo_q    <= bo_d;
         br_q    <= br_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign d3   = d_q[3];
   assign d2   = d_q[2];
   assign d1   = d_q[1];
   assign d0   = d_q[0];
   assign bo4  = bo_q[3];
   assign bo3  = bo_q[2];
   assign bo2  = bo_q[1];
   assign bo1  = bo_q[0];

endmodule

// File: tb/tb_sub4_serial.sv
// Scoreboard bench for sub4_serial: pulse-mode and level-mode instances share stimulus.
module tb_sub4_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;

   logic busy_p, done_p, busy_l, done_l;
   wire [3:0] d_p, bo_p, d_l, bo_l;

   int errors = 0;
   int checks = 0;

   logic [7:0] q_p[$];
   logic [7:0] q_l[$];

   sub4_serial #(.DONE_PULSE(1'b1)) dut_p (
      .clk(clk), .rst(rst), .start(start),
      .a3(a[3]), .a2(a[2]), .a1(a[1]), .a0(a[0]),
      .b3(b[3]), .b2(b[2]), .b1(b[1]), .b0(b[0]),
      .busy(busy_p), .done(done_p),
      .d3(d_p[3]), .d2(d_p[2]), .d1(d_p[1]), .d0(d_p[0]),
      .bo4(bo_p[3]), .bo3(bo_p[2]), .bo2(bo_p[1]), .bo1(bo_p[0])
   );

   sub4_serial #(.DONE_PULSE(1'b0)) dut_l (
      .clk(clk), .rst(rst), .start(start),
      .a3(a[3]), .a2(a[2]), .a1(a[1]), .a0(a[0]),
      .b3(b[3]), .b2(b[2]), .b1(b[1]), .b0(b[0]),
      .busy(busy_l), .done(done_l),
      .d3(d_l[3]), .d2(d_l[2]), .d1(d_l[1]), .d0(d_l[0]),
      .bo4(bo_l[3]), .bo3(bo_l[2]), .bo2(bo_l[1]), .bo1(bo_l[0])
   );

   // Reference: modulo-16 difference; borrow out of stage i is set when the
   // low i+1 bits of A are smaller than the low i+1 bits of B.
   function automatic logic [7:0] model(input logic [3:0] av, input logic [3:0] bv);
      int ai, bi, m;
      logic [3:0] dd, bb;
      ai = int'(av);
      bi = int'(bv);
      dd = 4'((ai - bi + 16) % 16);
      for (int i = 0; i < 4; i++) begin
         m = (1 << (i + 1)) - 1;
         bb[i] = ((ai & m) < (bi & m));
      end
      return {dd, bb};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each rising edge of done pops one expected result per instance.
   logic done_p_prev = 1'b0;
   logic done_l_prev = 1'b0;
   always @(negedge clk) begin
      logic [7:0] exp;
      if (!rst && done_p && !done_p_prev) begin
         checks++;
         if (q_p.size() == 0) begin
            errors++;
            $display("FAIL done_p_unexpected: got result %h with no pending operation", {d_p, bo_p});
         end else begin
            exp = q_p.pop_front();
            if ({d_p, bo_p} !== exp) begin
               errors++;
               $display("FAIL result_p: got d=%b bo=%b expected d=%b bo=%b", d_p, bo_p, exp[7:4], exp[3:0]);
            end
         end
      end
      if (!rst && done_l && !done_l_prev) begin
         checks++;
         if (q_l.size() == 0) begin
            errors++;
            $display("FAIL done_l_unexpected: got result %h with no pending operation", {d_l, bo_l});
         end else begin
            exp = q_l.pop_front();
            if ({d_l, bo_l} !== exp) begin
               errors++;
               $display("FAIL result_l: got d=%b bo=%b expected d=%b bo=%b", d_l, bo_l, exp[7:4], exp[3:0]);
            end
         end
      end
      done_p_prev = rst ? 1'b0 : done_p;
      done_l_prev = rst ? 1'b0 : done_l;
   end

   // Issue one operation from a negedge where both instances are not busy.
   task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input bit disturb, input bit hold);
      int cyc;
      a = av;
      b = bv;
      start = 1'b1;
      q_p.push_back(model(av, bv));
      q_l.push_back(model(av, bv));
      @(negedge clk);
      check("accept_busy_p", int'(busy_p), 1);
      check("accept_busy_l", int'(busy_l), 1);
      if (!hold) start = 1'b0;
      cyc = 1;
      while (busy_p && cyc < 10) begin
         if (disturb) begin
            a = 4'($urandom);
            b = 4'($urandom);
            start = ($urandom_range(0, 1) == 1);
         end
         @(negedge clk);
         cyc++;
      end
      if (!hold) start = 1'b0;
      check("busy_cycles", cyc, 5);
      check("done_at_end_p", int'(done_p), 1);
      check("done_at_end_l", int'(done_l), 1);
   endtask

   task automatic idle_check(input logic [3:0] av, input logic [3:0] bv);
      a = 4'($urandom);
      b = 4'($urandom);
      repeat (2) @(negedge clk);
      check("idle_done_p", int'(done_p), 0);
      check("idle_done_l", int'(done_l), 1);
      check("idle_busy_p", int'(busy_p), 0);
      check("hold_result_p", int'({d_p, bo_p}), int'(model(av, bv)));
      check("hold_result_l", int'({d_l, bo_l}), int'(model(av, bv)));
   endtask

   initial begin
      logic [3:0] ra, rb;
      logic [3:0] va[4];
      logic [3:0] vb[4];

      // Reset wins over start
      rst = 1'b1;
      start = 1'b1;
      a = 4'd15;
      b = 4'd1;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy_p), 0);
      check("rst_done", int'(done_p), 0);
      check("rst_d", int'(d_p), 0);
      check("rst_bo", int'(bo_p), 0);
      check("rst_done_l", int'(done_l), 0);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_rst_idle", int'(busy_p), 0);

      va[0] = 4'd9;  vb[0] = 4'd3;
      va[1] = 4'd3;  vb[1] = 4'd9;
      va[2] = 4'd0;  vb[2] = 4'd0;
      va[3] = 4'd0;  vb[3] = 4'd15;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], 1'b0, 1'b0);
         idle_check(va[i], vb[i]);
      end

      // Operand and start changes during RUN must be ignored
      run_op(4'd12, 4'd5, 1'b1, 1'b0);
      idle_check(4'd12, 4'd5);

      // Back-to-back with start held high: next op is taken in the DONE cycle
      for (int i = 0; i < 4; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         run_op(ra, rb, 1'b0, 1'b1);
      end
      start = 1'b0;
      idle_check(ra, rb);

      // Reset on the second RUN cycle aborts the operation
      a = 4'd7;
      b = 4'd2;
      start = 1'b1;
      q_p.push_back(model(4'd7, 4'd2));
      q_l.push_back(model(4'd7, 4'd2));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(q_p.pop_back());
      void'(q_l.pop_back());
      check("abort_busy", int'(busy_p), 0);
      check("abort_done_p", int'(done_p), 0);
      check("abort_done_l", int'(done_l), 0);
      check("abort_out_p", int'({d_p, bo_p}), 0);
      check("abort_out_l", int'({d_l, bo_l}), 0);
      repeat (6) @(negedge clk);
      check("abort_stays_idle", int'(busy_p), 0);

      // Random operations with random gaps
      for (int i = 0; i < 20; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         run_op(ra, rb, ($urandom_range(0, 3) == 0), 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      repeat (3) @(negedge clk);

      check("pending_p", q_p.size(), 0);
      check("pending_l", q_l.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
